alu_op_sequencer: RTL and testbench

- Initiator side of the 8-bit ALU control/operand interface.
- Accepts ALU operation requests over a valid/ready handshake and drives the ALU's operand and control inputs (A, B, carry_in, is_shift, scode, acode) for one execute cycle.
- Registers the ALU's R/zero/carry_out at the end of that cycle and returns them over a valid/ready response channel.
- Owns the architectural carry flag consumed by ADC/SBC; sits between the datapath controller and the combinational ALU.

---
 rtl/alu_op_sequencer_if.sv | 25 ++
 rtl/alu_op_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/response channel between the datapath controller (master) and
// the ALU operation sequencer (slave).
interface alu_op_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_r;
  logic       rsp_zero;
  logic       rsp_carry;
  logic       rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_zero, rsp_carry, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_zero, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one request, drives the combinational
// ALU for a single execute cycle, captures its result and returns it over
// the response channel. Owns the architectural carry flag.
module alu_op_sequencer #(
  parameter logic CARRY_RST = 1'b0,
  parameter logic ERR_ZERO  = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  alu_op_sequencer_if.slave         bus,
  output logic [7:0]                alu_a_o,
  output logic [7:0]                alu_b_o,
  output logic                      alu_carry_in_o,
  output logic                      alu_is_shift_o,
  output logic [1:0]                alu_scode_o,
  output logic [2:0]                alu_acode_o,
  input  logic [7:0]                alu_r_i,
  input  logic                      alu_zero_i,
  input  logic                      alu_carry_out_i
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_CLC = 4'd15;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q;
  logic [3:0] op_q;
  logic       carry_q;
  logic       req_ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_r_q;
  logic       rsp_zero_q;
  logic       rsp_carry_q;
  logic       rsp_err_q;

  logic [7:0] alu_a_q, alu_b_q;
  logic       alu_cin_q, alu_shift_q;
  logic [1:0] alu_scode_q;
  logic [2:0] alu_acode_q;

  logic [7:0] alu_a_d, alu_b_d;
  logic       alu_cin_d, alu_shift_d;
  logic [1:0] alu_scode_d;
  logic [2:0] alu_acode_d;

  logic       accept;

  assign accept = (state_q == IDLE) && req_ready_q && bus.req_valid;

  // Decode the incoming request into the ALU control word latched at accept.
  // CLC and illegal opcodes leave the ALU controls idle.
  always_comb begin
    alu_a_d     = '0;
    alu_b_d     = '0;
    alu_cin_d   = 1'b0;
    alu_shift_d = 1'b0;
    alu_scode_d = '0;
    alu_acode_d = '0;
    case (bus.req_op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR: begin
        alu_a_d     = bus.req_a;
        alu_b_d     = bus.req_b;
        alu_cin_d   = carry_q;
        alu_acode_d = bus.req_op[2:0];
      end
      OP_SLL, OP_SRA, OP_ROL: begin
        alu_a_d     = bus.req_a;
        alu_b_d     = {5'b0, bus.req_b[2:0]};
        alu_cin_d   = carry_q;
        alu_shift_d = 1'b1;
        alu_scode_d = bus.req_op[1:0];
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered handshake, ALU control and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      carry_q     <= CARRY_RST;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_r_q     <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= CARRY_RST;
      rsp_err_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_shift_q <= 1'b0;
      alu_scode_q <= '0;
      alu_acode_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q        <= bus.req_op;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_shift_q <= alu_shift_d;
            alu_scode_q <= alu_scode_d;
            alu_acode_q <= alu_acode_d;
            req_ready_q <= 1'b0;
            state_q     <= EXEC;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        EXEC: begin
          alu_a_q     <= '0;
          alu_b_q     <= '0;
          alu_cin_q   <= 1'b0;
          alu_shift_q <= 1'b0;
          alu_scode_q <= '0;
          alu_acode_q <= '0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
          case (op_q)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
              rsp_r_q     <= alu_r_i;
              rsp_zero_q  <= alu_zero_i;
              rsp_err_q   <= 1'b0;
              carry_q     <= alu_carry_out_i;
              rsp_carry_q <= alu_carry_out_i;
            end
            OP_AND, OP_XOR, OP_SLL, OP_SRA, OP_ROL: begin
              rsp_r_q     <= alu_r_i;
              rsp_zero_q  <= alu_zero_i;
              rsp_err_q   <= 1'b0;
              rsp_carry_q <= carry_q;
            end
            OP_CLC: begin
              rsp_r_q     <= '0;
              rsp_zero_q  <= 1'b1;
              rsp_err_q   <= 1'b0;
              carry_q     <= 1'b0;
              rsp_carry_q <= 1'b0;
            end
            default: begin
              rsp_r_q     <= '0;
              rsp_zero_q  <= ERR_ZERO;
              rsp_err_q   <= 1'b1;
              rsp_carry_q <= carry_q;
            end
          endcase
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_r      = rsp_r_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_err    = rsp_err_q;

  assign alu_a_o        = alu_a_q;
  assign alu_b_o        = alu_b_q;
  assign alu_carry_in_o = alu_cin_q;
  assign alu_is_shift_o = alu_shift_q;
  assign alu_scode_o    = alu_scode_q;
  assign alu_acode_o    = alu_acode_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer with a behavioural ALU.
module tb_alu_op_sequencer;

  localparam logic CARRY_RST = 1'b0;
  localparam logic ERR_ZERO  = 1'b0;

  typedef struct {
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] alu_a, alu_b, alu_r;
  logic       alu_cin, alu_shift, alu_zero, alu_cout;
  logic [1:0] alu_scode;
  logic [2:0] alu_acode;

  int   vectors     = 0;
  int   miscompares = 0;
  logic mc;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.CARRY_RST(CARRY_RST), .ERR_ZERO(ERR_ZERO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .alu_a_o         (alu_a),
    .alu_b_o         (alu_b),
    .alu_carry_in_o  (alu_cin),
    .alu_is_shift_o  (alu_shift),
    .alu_scode_o     (alu_scode),
    .alu_acode_o     (alu_acode),
    .alu_r_i         (alu_r),
    .alu_zero_i      (alu_zero),
    .alu_carry_out_i (alu_cout)
  );

  // Behavioural ALU: subtraction carry_out is the borrow.
  logic [8:0]  t;
  logic [15:0] rot;
  always_comb begin
    t   = '0;
    rot = {alu_a, alu_a} << alu_b[2:0];
    if (alu_shift) begin
      case (alu_scode)
        2'd0:    t = {1'b0, alu_a << alu_b[2:0]};
        2'd1:    t = {1'b0, 8'($signed(alu_a) >>> alu_b[2:0])};
        2'd2:    t = {1'b0, rot[15:8]};
        default: t = '0;
      endcase
    end else begin
      case (alu_acode)
        3'd0:    t = {1'b0, alu_a} + {1'b0, alu_b};
        3'd1:    t = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
        3'd2:    t = {1'b0, alu_a} - {1'b0, alu_b};
        3'd3:    t = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_cin};
        3'd4:    t = {1'b0, alu_a & alu_b};
        3'd6:    t = {1'b0, alu_a ^ alu_b};
        default: t = '0;
      endcase
    end
  end
  assign alu_r    = t[7:0];
  assign alu_cout = t[8];
  assign alu_zero = (t[7:0] == 8'h00);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference result from opcode semantics and current carry flag.
  function automatic exp_t ref_op(input logic [3:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic cin);
    exp_t e;
    int   sh;
    sh  = int'(b[2:0]);
    e.e = 1'b0;
    e.c = cin;
    e.r = 8'h00;
    case (op)
      4'd0: begin e.r = a + b;        e.c = (int'(a) + int'(b)) > 255; end
      4'd1: begin e.r = a + b + 8'(cin); e.c = (int'(a) + int'(b) + int'(cin)) > 255; end
      4'd2: begin e.r = a - b;        e.c = int'(a) < int'(b); end
      4'd3: begin e.r = a - b - 8'(cin); e.c = int'(a) < (int'(b) + int'(cin)); end
      4'd4: e.r = a & b;
      4'd6: e.r = a ^ b;
      4'd8: e.r = 8'(int'(a) << sh);
      4'd9: e.r = 8'((int'(a) - (a[7] ? 256 : 0)) >>> sh);
      4'd10: e.r = 8'((int'(a) << sh) | (int'(a) >> (8 - sh)));
      4'd15: e.c = 1'b0;
      default: e.e = 1'b1;
    endcase
    e.z = e.e ? ERR_ZERO : (e.r == 8'h00);
    return e;
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int hold);
    exp_t       e, got;
    logic [7:0] ea, eb;
    logic       ecin, esh;
    logic [1:0] esc;
    logic [2:0] eac;
    int         n;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_wait", 32'(n < 20), 32'd1);
    ea = 8'h00; eb = 8'h00; ecin = 1'b0; esh = 1'b0; esc = 2'd0; eac = 3'd0;
    if (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6}) begin
      ea = a; eb = b; ecin = mc; eac = op[2:0];
    end else if (op inside {4'd8, 4'd9, 4'd10}) begin
      ea = a; eb = {5'b0, b[2:0]}; ecin = mc; esh = 1'b1; esc = op[1:0];
    end
    e = ref_op(op, a, b, mc);
    sb.push_back(e);
    mc = e.c;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("exec_req_ready", 32'(bus.req_ready), 32'd0);
    check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("exec_alu_a", 32'(alu_a), 32'(ea));
    check("exec_alu_b", 32'(alu_b), 32'(eb));
    check("exec_alu_cin", 32'(alu_cin), 32'(ecin));
    check("exec_alu_shift", 32'(alu_shift), 32'(esh));
    check("exec_alu_scode", 32'(alu_scode), 32'(esc));
    check("exec_alu_acode", 32'(alu_acode), 32'(eac));
    @(posedge clk); #1;
    check("rsp_latency", 32'(bus.rsp_valid), 32'd1);
    check("resp_alu_idle", 32'({alu_a, alu_b, alu_shift, alu_cin}), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_rsp_r", 32'(bus.rsp_r), 32'(sb[0].r));
      check("hold_rsp_carry", 32'(bus.rsp_carry), 32'(sb[0].c));
    end
    got = sb.pop_front();
    check("rsp_r", 32'(bus.rsp_r), 32'(got.r));
    check("rsp_zero", 32'(bus.rsp_zero), 32'(got.z));
    check("rsp_carry", 32'(bus.rsp_carry), 32'(got.c));
    check("rsp_err", 32'(bus.rsp_err), 32'(got.e));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    mc            = CARRY_RST;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_r", 32'(bus.rsp_r), 32'd0);
    check("rst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
    check("rst_rsp_carry", 32'(bus.rsp_carry), 32'(CARRY_RST));
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_alu_idle", 32'({alu_a, alu_b, alu_cin, alu_shift, alu_scode, alu_acode}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // rsp_ready without a pending response must be ignored
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("stray_req_ready", 32'(bus.req_ready), 32'd1);

    do_op(4'd0,  8'hFF, 8'h01, 0);   // ADD -> 00, zero, carry
    do_op(4'd1,  8'h00, 8'h00, 0);   // ADC uses carry=1 -> 01
    do_op(4'd0,  8'hFF, 8'h01, 0);   // set carry again
    do_op(4'd6,  8'h0F, 8'h0F, 0);   // XOR keeps carry
    do_op(4'd15, 8'h55, 8'hAA, 0);   // CLC
    do_op(4'd8,  8'h03, 8'hF9, 0);   // SLL by 1, upper b ignored
    do_op(4'd0,  8'h80, 8'h80, 0);   // carry = 1
    do_op(4'd7,  8'h12, 8'h34, 5);   // illegal, held response
    do_op(4'd2,  8'h05, 8'h07, 0);   // SUB with borrow
    do_op(4'd3,  8'h10, 8'h0F, 1);   // SBC consumes borrow
    do_op(4'd4,  8'hF0, 8'h3C, 0);   // AND
    do_op(4'd9,  8'h80, 8'h01, 0);   // SRA
    do_op(4'd10, 8'h81, 8'h0B, 0);   // ROL by 3
    do_op(4'd12, 8'hAA, 8'h55, 2);   // illegal
    do_op(4'd0,  8'hF0, 8'h20, 0);   // carry = 1 before reset

    // Reset while the next request is in EXEC
    bus.req_op    = 4'd0;
    bus.req_a     = 8'h01;
    bus.req_b     = 8'h01;
    bus.req_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      check("mid_rst_wait", 32'(n < 20), 32'd1);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("mid_rst_exec_a", 32'(alu_a), 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_carry", 32'(bus.rsp_carry), 32'(CARRY_RST));
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mc    = CARRY_RST;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    do_op(4'd1,  8'h01, 8'h02, 0);   // ADC sees reset carry
    do_op(4'd0,  8'h01, 8'h02, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
